muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS datapath, implementing MULT, MULTU, DIV and DIVU into the architectural HI/LO registers. It accepts operands from the EX stage, runs for a fixed number of cycles while the hazard logic stalls the pipeline on `busy`, then commits HI/LO. Its `hilo_out` port feeds input 2 of the 32-bit three-input result multiplexer, which serves MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit feeding the architectural HI/LO pair.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both work on
// operand magnitudes and fix up the sign in the final state.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_hi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hilo_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic             is_div;   // latched op[1]
   logic [WIDTH-1:0] a_q;      // multiplicand magnitude
   logic [WIDTH-1:0] b_q;      // divisor magnitude
   logic [WIDTH-1:0] a_raw;    // unmodified dividend, returned in HI on divide by zero
   logic             div0;
   logic             neg_q;    // product/quotient sign
   logic             neg_r;    // remainder sign
   logic [2*WIDTH-1:0] acc;    // multiply: {partial product, multiplier}; divide: low half = dividend/quotient
   logic [WIDTH:0]   rem;      // divide partial remainder
   logic [WIDTH-1:0] hi, lo;
   logic             done_q;

   // operand magnitudes for signed ops
   logic             sgn_a, sgn_b;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign sgn_a = op[0] & src_a[WIDTH-1];
   assign sgn_b = op[0] & src_b[WIDTH-1];
   assign a_mag = sgn_a ? -src_a : src_a;
   assign b_mag = sgn_b ? -src_b : src_b;

   // one iteration of each algorithm
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift, div_sub;
   logic             div_ge;
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
   assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, b_q};
   assign div_sub   = div_shift - {1'b0, b_q};

   // sign fix-up applied at commit
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod_fix = neg_q ? -acc : acc;
   assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state decode and busy output
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_nx = FIN;
         end
         FIN: begin
            busy     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // datapath: operand latch, iteration, commit and MTHI/MTLO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         is_div <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         a_raw  <= '0;
         div0   <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         acc    <= '0;
         rem    <= '0;
         hi     <= '0;
         lo     <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == FIN);
         case (state)
            IDLE: begin
               if (start) begin
                  cnt    <= '0;
                  is_div <= op[1];
                  a_q    <= a_mag;
                  b_q    <= b_mag;
                  a_raw  <= src_a;
                  div0   <= op[1] & (src_b == '0);
                  neg_q  <= sgn_a ^ sgn_b;
                  neg_r  <= sgn_a;
                  rem    <= '0;
                  // multiply starts with the multiplier in the low half,
                  // divide starts with the dividend in the low half
                  acc    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  rem <= div_ge ? div_sub : div_shift;
                  acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               end
            end
            FIN: begin
               if (div0) begin
                  hi <= a_raw;
                  lo <= '1;
               end else if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign done     = done_q;
   assign hilo_out = rd_hi ? hi : lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes reference results,
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0, src_b = '0, wdata = '0;
   logic        mthi = 1'b0, mtlo = 1'b0;
   logic        rd_hi;
   logic        busy, done;
   logic [31:0] hilo_out;

   // rd_hi is shared: the monitor takes it while reading a result
   logic mon_active = 1'b0, mon_sel = 1'b0, stim_sel = 1'b0;
   assign rd_hi = mon_active ? mon_sel : stim_sel;

   int checks = 0, errors = 0;
   int cyc = 0, issue_cyc = 0, done_cnt = 0;
   logic [63:0] sb[$];

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
      .wdata(wdata), .rd_hi(rd_hi), .busy(busy), .done(done),
      .hilo_out(hilo_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // reference: {HI,LO} from plain arithmetic
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [31:0] q, r;
      case (o)
         2'd0: return {32'b0, a} * {32'b0, b};
         2'd1: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
         end
         2'd2: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            q = a / b; r = a % b;
            return {r, q};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
            return {r, q};
         end
      endcase
   endfunction

   // monitor: read HI then LO during the done cycle and compare
   initial begin
      logic [31:0] ah, al;
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            mon_active = 1'b1; mon_sel = 1'b1;
            #1 ah = hilo_out; mon_sel = 1'b0;
            #1 al = hilo_out; mon_active = 1'b0;
            done_cnt++;
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done actual=%h expected=none", {ah, al});
            end else begin
               e = sb.pop_front();
               chk("result", {ah, al}, e);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; src_a = a; src_b = b; start = 1'b1;
      sb.push_back(model(o, a, b));
      @(posedge clk);
      #1 issue_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(output int dcyc, output int bcnt);
      bcnt = 0; dcyc = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin dcyc = cyc; break; end
         if (busy === 1'b1) bcnt++;
      end
      if (dcyc < 0) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=none expected=done within 60 cycles");
      end else begin
         chk("busy_at_done", busy, 0);
         chk("latency", dcyc - issue_cyc, 33);
      end
   endtask

   task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
      stim_sel = 1'b1; #1 h = hilo_out;
      stim_sel = 1'b0; #1 l = hilo_out;
   endtask

   initial begin
      int d1, d2, bc, saved;
      logic [31:0] h, l;
      logic [63:0] tmp;

      // asynchronous reset with no clock edge yet
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      read_hl(h, l);
      chk("rst_hilo", {h, l}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // MULTU max x max, busy width and done width
      issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(d1, bc);
      chk("busy_cycles", bc, 33);
      @(negedge clk);
      chk("done_width", done, 0);

      // signed multiply / divide and boundary divides
      issue(2'd1, 32'hFFFFFFFD, 32'd5);          wait_done(d1, bc);
      issue(2'd3, 32'hFFFFFFF9, 32'd2);          wait_done(d1, bc);
      issue(2'd2, 32'h12345678, 32'd0);          wait_done(d1, bc);
      issue(2'd3, 32'h80000000, 32'hFFFFFFFF);   wait_done(d1, bc);
      issue(2'd3, 32'h87654321, 32'd0);          wait_done(d1, bc);
      issue(2'd3, 32'd7, 32'hFFFFFFFE);          wait_done(d1, bc);
      @(negedge clk);

      // MTHI / MTLO in idle
      mthi = 1'b1; wdata = 32'hAAAA5555;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b1; wdata = 32'h0F0F0F0F;
      @(negedge clk);
      mtlo = 1'b0;
      read_hl(h, l);
      chk("mt_hilo", {h, l}, 64'hAAAA5555_0F0F0F0F);

      // start and mthi while busy are ignored
      @(negedge clk);
      issue(2'd0, 32'h12345678, 32'h00009ABC);
      repeat (10) @(negedge clk);
      start = 1'b1; op = 2'd3; src_a = 32'h11111111; src_b = 32'h3;
      mthi = 1'b1; wdata = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      read_hl(h, l);
      chk("hold_mid1", {h, l}, 64'hAAAA5555_0F0F0F0F);
      repeat (15) @(negedge clk);
      read_hl(h, l);
      chk("hold_mid2", {h, l}, 64'hAAAA5555_0F0F0F0F);
      wait_done(d1, bc);
      @(negedge clk);

      // reset in the middle of iteration 15 of a DIVU
      issue(2'd2, 32'hFEDCBA98, 32'h00000123);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      read_hl(h, l);
      chk("abort_hilo", {h, l}, 64'h0);
      tmp = sb.pop_back();
      saved = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_no_done", done_cnt, saved);
      chk("abort_idle", busy, 0);
      issue(2'd0, 32'd3, 32'd4);
      wait_done(d1, bc);

      // back-to-back issue on the edge where done drops
      issue(2'd2, 32'd100, 32'd7);
      wait_done(d1, bc);
      issue(2'd1, 32'h80000000, 32'h80000000);
      wait_done(d2, bc);
      chk("b2b_interval", d2 - d1, 34);

      // randomized ops, issued back to back
      for (int i = 0; i < 24; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
         issue(ro, ra, rb);
         wait_done(d1, bc);
      end

      repeat (5) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard stop in case something wedges
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
